rd_resp: RTL and testbench

RD_RESP -- requirements
Module: rd_resp

---
 rtl/rd_resp.sv | 179 +++++++++++++++++
 tb/tb_rd_resp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_resp.sv
// -----------------------------------------------------------------------------
// rd_resp -- polled read responder
//
// An initiator raises rd and keeps it high while the read is outstanding. The
// responder holds ws=1 (initiator re-polls) until two things are true: at least
// wait_cfg cycles have elapsed and a word has been taken from the upstream
// valid/ready source. It then shows the word on rdata with ws=0. The initiator
// pulses ds to say it has taken rdata, which bumps rd_cnt.
//
// Ports
//   clk        in   clock, all state updates on its rising edge
//   rst_n      in   asynchronous active-low reset
//   rd         in   read request, held high while outstanding
//   ds         in   done strobe, rdata has been consumed
//   ws         out  wait state, 1 = data not ready yet
//   rdata      out  [DW]  read data, valid while READY
//   wait_cfg   in   [WAIT_W] minimum wait cycles per read
//   src_valid  in   upstream word available
//   src_data   in   [DW] upstream word
//   src_ready  out  responder accepts src_data this cycle
//   rd_cnt     out  [16] completed reads, wraps to 0
//   err        out  sticky protocol error (ds outside READY)
//   rpar       out  even parity of rdata (only with RD_RESP_PARITY_EN)
//
// Build option: define RD_RESP_PARITY_EN to add the rpar output and an
// X-on-capture check that sets err in simulation.
// -----------------------------------------------------------------------------
module rd_resp #(
   parameter int DW     = 8,
   parameter int WAIT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic              ds,
   output logic              ws,
   output logic [DW-1:0]     rdata,
   input  logic [WAIT_W-1:0] wait_cfg,
   input  logic              src_valid,
   input  logic [DW-1:0]     src_data,
   output logic              src_ready,
   output logic [15:0]       rd_cnt,
   output logic              err
`ifdef RD_RESP_PARITY_EN
   ,
   output logic              rpar
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [WAIT_W-1:0] WCNT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic [WAIT_W-1:0] wcnt_dec;
   logic              cap_q, cap_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [15:0]       rd_cnt_q, rd_cnt_d;
   logic              err_q, err_d;
   logic              capture;
`ifdef RD_RESP_PARITY_EN
   logic              rpar_q, rpar_d;
`endif

   // Outputs are decoded from registered state only, so rd/ds never reach ws
   // combinationally.
   assign ws        = (state_q == BUSY);
   assign src_ready = (state_q == BUSY) && !cap_q;
   assign rdata     = rdata_q;
   assign rd_cnt    = rd_cnt_q;
   assign err       = err_q;
`ifdef RD_RESP_PARITY_EN
   assign rpar      = rpar_q;
`endif

   // Saturating decrement of the wait counter.
   assign wcnt_dec = (wcnt_q == '0) ? '0 : (wcnt_q - WCNT_ONE);

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      cap_d    = cap_q;
      rdata_d  = rdata_q;
      rd_cnt_d = rd_cnt_q;
      err_d    = err_q;
      capture  = 1'b0;

      if (ds && (state_q != READY)) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rd) begin
               wcnt_d = wait_cfg;
               cap_d  = 1'b0;
               // Zero wait and data already there: skip BUSY entirely.
               if ((wait_cfg == '0) && src_valid) begin
                  capture = 1'b1;
                  rdata_d = src_data;
                  state_d = READY;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // src_ready is already high this cycle, so a handshake completes
            // even if rd drops; on abort the word is simply thrown away.
            if (src_valid && !cap_q) begin
               capture = 1'b1;
               rdata_d = src_data;
               cap_d   = 1'b1;
            end
            if (!rd) begin
               cap_d   = 1'b0;
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt_dec;
               // The counter reaching zero on this edge ends the wait, so a
               // wait_cfg of N gives exactly N cycles of ws=1.
               if ((wcnt_dec == '0) && (cap_q || capture)) begin
                  state_d = READY;
               end
            end
         end
         READY: begin
            if (ds) begin
               rd_cnt_d = rd_cnt_q + 16'd1;
               state_d  = IDLE;
            end else if (!rd) begin
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = state_t'(2'bxx);
         end
      endcase

`ifdef RD_RESP_PARITY_EN
      rpar_d = ^rdata_d;
`ifndef SYNTHESIS
      if (capture && $isunknown(src_data)) begin
         err_d = 1'b1;
      end
`endif
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         cap_q    <= 1'b0;
         rdata_q  <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
`ifdef RD_RESP_PARITY_EN
         rpar_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         cap_q    <= cap_d;
         rdata_q  <= rdata_d;
         rd_cnt_q <= rd_cnt_d;
         err_q    <= err_d;
`ifdef RD_RESP_PARITY_EN
         rpar_q   <= rpar_d;
`endif
      end
   end

endmodule

// File: tb/tb_rd_resp.sv
// -----------------------------------------------------------------------------
// tb_rd_resp -- self-checking bench for rd_resp (DW=8, WAIT_W=4).
// Expected read data is queued when a read is launched and popped when the
// responder drops ws; timing, handshake, counter and error flag are checked
// against bench-side expectations.
// -----------------------------------------------------------------------------
module tb_rd_resp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd;
   logic        ds;
   logic        ws;
   logic [7:0]  rdata;
   logic [3:0]  wait_cfg;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        src_ready;
   logic [15:0] rd_cnt;
   logic        err;
`ifdef RD_RESP_PARITY_EN
   logic        rpar;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  sb_q[$];
   logic [15:0] exp_cnt;
   logic        exp_err;

   rd_resp #(.DW(8), .WAIT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd        (rd),
      .ds        (ds),
      .ws        (ws),
      .rdata     (rdata),
      .wait_cfg  (wait_cfg),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .rd_cnt    (rd_cnt),
      .err       (err)
`ifdef RD_RESP_PARITY_EN
      ,
      .rpar      (rpar)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle, leaving us 1 time unit past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full read: launch with wait_cfg=wcfg, src_valid raised after d cycles,
   // stay in READY for hold cycles, then ds.
   task automatic run_read(input logic [3:0] wcfg, input logic [7:0] data,
                           input int d, input int hold);
      int         hi;
      int         exp_hi;
      int         dd;
      bit         done;
      logic [7:0] exp_d;
      hi     = 0;
      done   = 1'b0;
      dd     = (d > 0) ? d : 1;
      exp_hi = (int'(wcfg) > d) ? int'(wcfg) : d;
      wait_cfg  = wcfg;
      src_data  = data;
      src_valid = (d == 0);
      rd        = 1'b1;
      sb_q.push_back(data);
      for (int s = 1; s <= 40 && !done; s++) begin
         step();
         if (ws) begin
            hi++;
            check("src_ready_busy", 32'(src_ready), 32'(s <= dd));
         end else begin
            done = 1'b1;
         end
         if (s == d) src_valid = 1'b1;
      end
      check("rd_timeout", 32'(done), 32'd1);
      exp_d = sb_q.pop_front();
      check("ws_cycles", 32'(hi), 32'(exp_hi));
      check("rdata", 32'(rdata), 32'(exp_d));
      check("src_ready_ready", 32'(src_ready), 32'd0);
`ifdef RD_RESP_PARITY_EN
      check("rpar", 32'(rpar), 32'(^exp_d));
`endif
      // Upstream moves on; rdata must not follow it.
      src_data  = ~data;
      src_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_ws", 32'(ws), 32'd0);
         check("hold_rdata", 32'(rdata), 32'(exp_d));
         check("hold_cnt", 32'(rd_cnt), 32'(exp_cnt));
      end
      ds = 1'b1;
      rd = 1'b0;
      step();
      ds        = 1'b0;
      src_valid = 1'b0;
      exp_cnt++;
      check("rd_cnt", 32'(rd_cnt), 32'(exp_cnt));
      check("err", 32'(err), 32'(exp_err));
      $display("read wcfg=%0d delay=%0d hold=%0d data=%02h ws_cycles=%0d rd_cnt=%04h",
               wcfg, d, hold, exp_d, hi, rd_cnt);
   endtask

   initial begin
      rst_n     = 1'b0;
      rd        = 1'b0;
      ds        = 1'b0;
      wait_cfg  = 4'd0;
      src_valid = 1'b0;
      src_data  = 8'h00;
      exp_cnt   = 16'd0;
      exp_err   = 1'b0;

      step();
      step();
      check("rst_ws", 32'(ws), 32'd0);
      check("rst_src_ready", 32'(src_ready), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_cnt", 32'(rd_cnt), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      step();

      // Zero wait, data present: READY on the first edge.
      run_read(4'd0, 8'hA5, 0, 0);
      // Wait of 3 with data ready, held in READY while re-polling.
      run_read(4'd3, 8'h5C, 0, 3);
      // Late source: valid appears 5 cycles in, wait of 1.
      run_read(4'd1, 8'h3C, 5, 1);
      // Zero wait but no data at launch.
      run_read(4'd0, 8'hE7, 3, 0);
      // Maximum wait.
      run_read(4'd15, 8'h81, 2, 1);

      for (int i = 0; i < 6; i++) begin
         run_read(4'($urandom_range(0, 5)), 8'($urandom), $urandom_range(0, 6),
                  $urandom_range(0, 2));
      end

      // Abort in BUSY.
      wait_cfg  = 4'd7;
      src_data  = 8'h77;
      src_valid = 1'b1;
      rd        = 1'b1;
      step();
      check("abort_busy_ws", 32'(ws), 32'd1);
      step();
      check("abort_busy_ws2", 32'(ws), 32'd1);
      rd = 1'b0;
      step();
      src_valid = 1'b0;
      check("abort_ws", 32'(ws), 32'd0);
      check("abort_src_ready", 32'(src_ready), 32'd0);
      check("abort_cnt", 32'(rd_cnt), 32'(exp_cnt));
      check("abort_err", 32'(err), 32'd0);
      $display("abort in BUSY rd_cnt=%04h", rd_cnt);
      run_read(4'd2, 8'h12, 3, 0);

      // READY left by dropping rd: no count; a following ds lands in IDLE.
      wait_cfg  = 4'd0;
      src_data  = 8'h5A;
      src_valid = 1'b1;
      rd        = 1'b1;
      step();
      check("drop_ready_ws", 32'(ws), 32'd0);
      check("drop_ready_rdata", 32'(rdata), 32'h5A);
      rd        = 1'b0;
      src_valid = 1'b0;
      step();
      ds = 1'b1;
      step();
      ds      = 1'b0;
      exp_err = 1'b1;
      check("drop_cnt", 32'(rd_cnt), 32'(exp_cnt));
      check("idle_ds_err", 32'(err), 32'd1);
      step();
      step();
      step();
      check("err_sticky", 32'(err), 32'd1);
      $display("ready drop then ds in IDLE err=%0d rd_cnt=%04h", err, rd_cnt);
      run_read(4'd1, 8'h66, 0, 0);

      // Counter wrap: stand in for 65533 earlier completed reads.
      force dut.rd_cnt_q = 16'hFFFD;
      #1;
      release dut.rd_cnt_q;
      exp_cnt = 16'hFFFD;
      run_read(4'd0, 8'h01, 0, 0);
      run_read(4'd2, 8'h02, 0, 0);
      run_read(4'd0, 8'h03, 1, 0);
      check("wrap_zero", 32'(rd_cnt), 32'd0);

      // Reset mid-read.
      wait_cfg  = 4'd5;
      src_data  = 8'h99;
      src_valid = 1'b1;
      rd        = 1'b1;
      step();
      step();
      check("pre_rst_ws", 32'(ws), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ws", 32'(ws), 32'd0);
      check("arst_src_ready", 32'(src_ready), 32'd0);
      check("arst_rdata", 32'(rdata), 32'd0);
      check("arst_cnt", 32'(rd_cnt), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      rd        = 1'b0;
      src_valid = 1'b0;
      step();
      step();
      rst_n   = 1'b1;
      exp_cnt = 16'd0;
      exp_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_idle_ws", 32'(ws), 32'd0);
      end
      $display("reset mid-read rd_cnt=%04h err=%0d", rd_cnt, err);
      run_read(4'd0, 8'hC3, 0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
